mem_arbiter: RTL and testbench

- Two-requester arbiter that lets the instruction cache and the data cache share one main-memory block port.
- Sits between the two caches' memory-side interfaces (read/write, block address, block data, busywait) and a single memory instance.
- Policy: round-robin. Exactly one transaction is forwarded to memory at a time, and each transaction is held until memory completes it.

---
 rtl/mem_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter letting the I-cache and D-cache share one memory block port.
// Exactly one transaction is in flight; each is held until memory completes it.
//
// Handshake: a cache raises its request (i_read, or d_read/d_write) and holds it
// with address/data stable while x_busywait is high.  x_busywait drops for exactly
// one cycle (DONE_x) when the transaction has completed; x_readdata is valid in that
// cycle and the cache consumes it at the following edge.  On the memory side the
// request lines and address/data are held from grant until memory has raised and
// then dropped mem_busywait.
module mem_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [DATA_W-1:0] i_readdata,
  output logic              i_busywait,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [DATA_W-1:0] d_writedata,
  output logic [DATA_W-1:0] d_readdata,
  output logic              d_busywait,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  input  logic              mem_busywait,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY_I = 3'd1,
    BUSY_D = 3'd2,
    DONE_I = 3'd3,
    DONE_D = 3'd4
  } state_t;

  state_t state;
  state_t state_next;
  logic   seen_busy;   // memory has acknowledged the current request
  logic   last_grant;  // 1 = D side won the previous grant
  logic   req_i;
  logic   req_d;
  logic   grant_i;
  logic   grant_d;
  logic   complete;

  assign req_i      = i_read;
  assign req_d      = d_read | d_write;
  assign i_busywait = req_i & (state != DONE_I);
  assign d_busywait = req_d & (state != DONE_D);
  assign state_dbg  = state;

  // Next-state: round-robin grant in IDLE, completion detect in BUSY, one-cycle DONE
  always_comb begin
    state_next = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    complete   = 1'b0;
    case (state)
      IDLE: begin
        if (req_i && (!req_d || last_grant)) begin
          grant_i    = 1'b1;
          state_next = BUSY_I;
        end else if (req_d) begin
          grant_d    = 1'b1;
          state_next = BUSY_D;
        end
      end
      BUSY_I: begin
        if (seen_busy && !mem_busywait) begin
          complete   = 1'b1;
          state_next = DONE_I;
        end
      end
      BUSY_D: begin
        if (seen_busy && !mem_busywait) begin
          complete   = 1'b1;
          state_next = DONE_D;
        end
      end
      DONE_I:  state_next = IDLE;
      DONE_D:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= IDLE;
    else        state <= state_next;
  end

  // Memory-side request registers, grant history and read-data capture
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      seen_busy     <= 1'b0;
      last_grant    <= 1'b1;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_address   <= '0;
      mem_writedata <= '0;
      i_readdata    <= '0;
      d_readdata    <= '0;
    end else begin
      if (grant_i) begin
        mem_address <= i_address;
        mem_read    <= 1'b1;
        mem_write   <= 1'b0;
        last_grant  <= 1'b0;
        seen_busy   <= 1'b0;
      end else if (grant_d) begin
        mem_address   <= d_address;
        mem_writedata <= d_writedata;
        mem_read      <= ~d_write;   // write wins when both are raised
        mem_write     <= d_write;
        last_grant    <= 1'b1;
        seen_busy     <= 1'b0;
      end else if (complete) begin
        if (state == BUSY_I) i_readdata <= mem_readdata;
        else if (mem_read)   d_readdata <= mem_readdata;
        mem_read  <= 1'b0;
        mem_write <= 1'b0;
      end else if ((state == BUSY_I || state == BUSY_D) && mem_busywait) begin
        seen_busy <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus two randomized caches, checked by a
// transaction-level model (who should win each grant, what each completion returns).
module tb_mem_arbiter;
  localparam int AW = 6;
  localparam int DW = 32;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          i_read;
  logic [AW-1:0] i_address;
  logic [DW-1:0] i_readdata;
  logic          i_busywait;
  logic          d_read;
  logic          d_write;
  logic [AW-1:0] d_address;
  logic [DW-1:0] d_writedata;
  logic [DW-1:0] d_readdata;
  logic          d_busywait;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_writedata;
  logic [DW-1:0] mem_readdata;
  logic          mem_busywait;
  logic [2:0]    state_dbg;

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK(CLK), .RESET(RESET),
    .i_read(i_read), .i_address(i_address), .i_readdata(i_readdata), .i_busywait(i_busywait),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_writedata(d_writedata),
    .d_readdata(d_readdata), .d_busywait(d_busywait),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata), .mem_busywait(mem_busywait),
    .state_dbg(state_dbg)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input int a);
    return 32'h5A00_0000 ^ (32'(a) * 32'h0001_0203);
  endfunction

  // ---------------- memory environment ----------------
  // Registers a request, holds busywait for a latency, then waits for lines to drop.
  logic [DW-1:0] mem_arr [64];
  logic          m_busy = 1'b0;
  logic          m_fin  = 1'b0;
  int            m_cnt  = 0;
  logic [AW-1:0] m_addr = '0;
  logic          m_wr   = 1'b0;
  logic [DW-1:0] m_wdata = '0;
  int            lat_fixed = 5;

  assign mem_busywait = m_busy;

  always @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      m_busy       <= 1'b0;
      m_fin        <= 1'b0;
      m_cnt        <= 0;
      mem_readdata <= '0;
      for (int k = 0; k < 64; k++) mem_arr[k] <= init_word(k);
    end else if (m_fin) begin
      if (!mem_read && !mem_write) m_fin <= 1'b0;
    end else if (m_busy) begin
      if (m_cnt <= 1) begin
        m_busy <= 1'b0;
        m_fin  <= 1'b1;
        if (m_wr) mem_arr[m_addr] <= m_wdata;
        else      mem_readdata    <= mem_arr[m_addr];
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end else if (mem_read || mem_write) begin
      m_busy  <= 1'b1;
      m_cnt   <= (lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, 5));
      m_addr  <= mem_address;
      m_wr    <= mem_write;
      m_wdata <= mem_writedata;
    end
  end

  // ---------------- reference model / scoreboard ----------------
  logic [32:0]   exp_q [$];        // {side (1 = D), expected readdata at completion}
  logic [DW-1:0] model_mem [64];
  int            last_win = 1;     // 0 = I, 1 = D
  logic          act = 1'b0;
  int            act_side = 0;
  logic          act_wr = 1'b0;
  logic [AW-1:0] act_addr = '0;
  logic [DW-1:0] act_wdata = '0;
  logic [DW-1:0] i_last = '0;
  logic [DW-1:0] d_last = '0;
  logic          prev_line = 1'b0;
  logic          done_prev = 1'b0;
  logic          p_ri = 1'b0, p_rd = 1'b0, p_dw = 1'b0;
  logic [AW-1:0] p_ia = '0, p_da = '0;
  logic [DW-1:0] p_dd = '0;

  always @(negedge CLK) begin
    logic        line;
    logic        req_d_now;
    logic        done_i;
    logic        done_d;
    int          exp_side;
    logic [32:0] e;
    line      = mem_read | mem_write;
    req_d_now = d_read | d_write;
    done_i    = i_read & ~i_busywait;
    done_d    = req_d_now & ~d_busywait;
    if (!RESET) begin
      last_win = 1;
      act      = 1'b0;
      i_last   = '0;
      d_last   = '0;
      exp_q.delete();
      for (int k = 0; k < 64; k++) model_mem[k] = init_word(k);
      done_prev = 1'b0;
    end else begin
      if (!i_read)    check("i_busy_noreq", 32'(i_busywait), 32'(0));
      if (!req_d_now) check("d_busy_noreq", 32'(d_busywait), 32'(0));
      if (done_prev)  check("turnaround_low", 32'(line), 32'(0));
      if (line && !prev_line) begin
        if (p_ri && p_rd) exp_side = 1 - last_win;
        else if (p_ri)    exp_side = 0;
        else if (p_rd)    exp_side = 1;
        else              exp_side = -1;
        check("grant_while_active", 32'(act), 32'(0));
        check("grant_has_request", 32'(exp_side >= 0), 32'(1));
        if (exp_side == 0) begin
          check("grant_i_addr", 32'(mem_address), 32'(p_ia));
          check("grant_i_rd", {30'd0, mem_read, mem_write}, 32'd2);
          act_wr   = 1'b0;
          act_addr = p_ia;
          e        = {1'b0, model_mem[p_ia]};
        end else begin
          check("grant_d_addr", 32'(mem_address), 32'(p_da));
          check("grant_d_rdwr", {30'd0, mem_read, mem_write}, {30'd0, ~p_dw, p_dw});
          if (p_dw) check("grant_d_wdata", mem_writedata, p_dd);
          act_wr    = p_dw;
          act_addr  = p_da;
          act_wdata = p_dd;
          e         = {1'b1, p_dw ? d_last : model_mem[p_da]};
        end
        if (exp_side >= 0) last_win = exp_side;
        act_side = exp_side;
        act      = 1'b1;
        exp_q.push_back(e);
      end else if (line && act) begin
        check("hold_addr", 32'(mem_address), 32'(act_addr));
        check("hold_rdwr", {30'd0, mem_read, mem_write}, {30'd0, ~act_wr, act_wr});
        if (act_wr) check("hold_wdata", mem_writedata, act_wdata);
      end
      if (done_i || done_d) begin
        check("done_single", 32'(done_i & done_d), 32'(0));
        check("done_in_flight", 32'(act), 32'(1));
        check("done_side", 32'(done_d), 32'(act_side));
        check("done_lines_low", 32'(line), 32'(0));
        check("done_mem_finished", 32'(m_fin), 32'(1));
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          if (done_i) begin
            check("i_readdata", i_readdata, e[31:0]);
            i_last = e[31:0];
          end else begin
            check("d_readdata", d_readdata, e[31:0]);
            d_last = e[31:0];
          end
        end
        if (act && act_wr && done_d) model_mem[act_addr] = act_wdata;
        act = 1'b0;
      end else begin
        if (!line && prev_line) check("lines_drop_without_done", 32'(line), 32'(prev_line));
        check("i_readdata_hold", i_readdata, i_last);
        check("d_readdata_hold", d_readdata, d_last);
      end
      done_prev = done_i | done_d;
    end
    prev_line = line & RESET;
    p_ri = i_read;
    p_rd = req_d_now;
    p_dw = d_write;
    p_ia = i_address;
    p_da = d_address;
    p_dd = d_writedata;
  end

  // ---------------- driver tasks ----------------
  // Waits (bounded) for the given side's completion cycle, then moves to posedge+1.
  task automatic wait_done(input int side, input string tag);
    int  n = 0;
    logic hit = 1'b0;
    while (!hit && n < 400) begin
      @(negedge CLK);
      n++;
      hit = (side == 0) ? (i_read & ~i_busywait) : ((d_read | d_write) & ~d_busywait);
    end
    check({tag, "_bounded"}, 32'(hit), 32'(1));
    @(posedge CLK); #1;
  endtask

  task automatic i_cache(input int n_txn);
    for (int t = 0; t < n_txn; t++) begin
      int gap = $urandom_range(0, 2);
      if (gap > 0) begin
        i_read = 1'b0;
        repeat (gap) begin @(posedge CLK); #1; end
      end
      i_read    = 1'b1;
      i_address = 6'($urandom_range(0, 63));
      wait_done(0, "rand_i");
    end
    i_read = 1'b0;
  endtask

  task automatic d_cache(input int n_txn);
    for (int t = 0; t < n_txn; t++) begin
      int gap  = $urandom_range(0, 2);
      int kind = $urandom_range(0, 3);
      if (gap > 0) begin
        d_read  = 1'b0;
        d_write = 1'b0;
        repeat (gap) begin @(posedge CLK); #1; end
      end
      d_read      = (kind != 2);
      d_write     = (kind >= 2);
      d_address   = 6'($urandom_range(0, 63));
      d_writedata = $urandom;
      wait_done(1, "rand_d");
    end
    d_read  = 1'b0;
    d_write = 1'b0;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int          n;
    int          side;
    logic        hit;
    RESET = 1'b0; i_read = 1'b1; i_address = 6'h11;
    d_read = 1'b0; d_write = 1'b0; d_address = '0; d_writedata = '0;
    lat_fixed = 5;
    repeat (3) @(posedge CLK); #1;
    // reset state with a pending I request
    check("rst_mem_read", 32'(mem_read), 32'(0));
    check("rst_mem_write", 32'(mem_write), 32'(0));
    check("rst_i_busy", 32'(i_busywait), 32'(1));
    check("rst_d_busy", 32'(d_busywait), 32'(0));
    check("rst_mem_addr", 32'(mem_address), 32'(0));
    check("rst_mem_wdata", mem_writedata, 32'(0));
    check("rst_i_rdata", i_readdata, 32'(0));
    check("rst_d_rdata", d_readdata, 32'(0));
    RESET = 1'b1;
    @(negedge CLK); @(negedge CLK);
    check("post_rst_mem_read", 32'(mem_read), 32'(1));
    check("post_rst_mem_addr", 32'(mem_address), 32'h11);
    wait_done(0, "post_rst");
    i_read = 1'b0;
    repeat (2) @(posedge CLK); #1;

    // D write 0x12345678 to 0x2A
    d_write = 1'b1; d_address = 6'h2A; d_writedata = 32'h1234_5678;
    wait_done(1, "d_write");
    check("d_write_rdata_kept", d_readdata, 32'(0));
    d_write = 1'b1; d_address = 6'h05; d_writedata = 32'hDEAD_BEEF;
    wait_done(1, "d_write2");
    d_write = 1'b0;
    @(posedge CLK); #1;

    // single I read of 0x05, then an immediate re-request pays one idle cycle
    i_read = 1'b1; i_address = 6'h05;
    wait_done(0, "i_read");
    check("i_read_data", i_readdata, 32'hDEAD_BEEF);
    @(negedge CLK);
    check("i_busy_after_done", 32'(i_busywait), 32'(1));
    check("idle_gap_mem_read", 32'(mem_read), 32'(0));
    wait_done(0, "i_reread");
    i_read = 1'b0;
    d_read = 1'b1; d_address = 6'h2A;
    wait_done(1, "d_readback");
    check("d_readback_data", d_readdata, 32'h1234_5678);
    d_read = 1'b0;
    @(posedge CLK); #1;

    // fairness from reset: continuous dual requests alternate I, D, I, D
    RESET = 1'b0;
    i_read = 1'b1; i_address = 6'h07;
    d_read = 1'b1; d_address = 6'h09;
    repeat (2) @(posedge CLK); #1;
    RESET = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n = 0; hit = 1'b0; side = -1;
      while (!hit && n < 400) begin
        @(negedge CLK);
        n++;
        if (!i_busywait)      begin hit = 1'b1; side = 0; end
        else if (!d_busywait) begin hit = 1'b1; side = 1; end
      end
      check("fair_bounded", 32'(hit), 32'(1));
      check("fair_order", 32'(side), 32'(k % 2));
    end
    @(posedge CLK); #1;
    i_read = 1'b0; d_read = 1'b0;
    repeat (2) @(posedge CLK); #1;

    // asynchronous reset while D is busy
    d_read = 1'b1; d_address = 6'h03;
    n = 0;
    while (!mem_read && n < 50) begin @(negedge CLK); n++; end
    check("busy_d_reached", 32'(mem_read), 32'(1));
    @(posedge CLK); #3;
    RESET = 1'b0;
    #1;
    check("async_mem_read", 32'(mem_read), 32'(0));
    check("async_mem_write", 32'(mem_write), 32'(0));
    check("async_mem_addr", 32'(mem_address), 32'(0));
    check("async_d_busy", 32'(d_busywait), 32'(1));
    @(negedge CLK); @(posedge CLK); #3;
    RESET = 1'b1;
    @(posedge CLK); #1;
    wait_done(1, "d_regrant");
    check("d_regrant_data", d_readdata, init_word(3));
    d_read = 1'b0;
    @(posedge CLK); #1;

    // randomized traffic from both caches with random latency
    lat_fixed = 0;
    fork
      i_cache(40);
      d_cache(40);
    join
    repeat (4) @(posedge CLK);
    check("end_queue_empty", 32'(exp_q.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    errors++;
    $display("FAIL global_timeout: simulation did not complete by t=%0t", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "global timeout");
  end

endmodule
